// File: rtl/img_pkg.sv
// Shared definitions for the frame rotator: rotation codes, mirror bit, luminance weights, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package img_pkg;

    // Rotation codes carried in mode[1:0], clockwise
    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    // mode[MIRROR_BIT] flips the output horizontally after rotation
    localparam int MIRROR_BIT = 2;

    // Luminance weights; they sum to 256 so the >>8 result fits one channel
    localparam int LUMA_R = 77;
    localparam int LUMA_G = 150;
    localparam int LUMA_B = 29;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/img_rot_addr_gen.sv
// Output raster counters plus rotation/mirror mapping to the source frame address.
// Latency: combinational address from registered counters; counters step on adv.
// Backpressure: counters hold whenever adv is low, so a stalled consumer freezes the read address.
module img_rot_addr_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H),
    localparam int XW = $clog2(IMG_W),
    localparam int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          adv,
    input  logic [2:0]    mode,
    output logic [XW+YW-1:0] src_addr,
    output logic [CW-1:0] a,
    output logic [CW-1:0] b,
    output logic          line_flag,
    output logic          last
);
    import img_pkg::*;

    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic [CW-1:0] ow_m1;
    logic [CW-1:0] oh_m1;
    logic [CW-1:0] xm;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;

    // Output dimensions swap for the quarter turns; mirror applies on the output column
    always_comb begin
        ow_m1 = mode[0] ? CW'(IMG_H - 1) : CW'(IMG_W - 1);
        oh_m1 = mode[0] ? CW'(IMG_W - 1) : CW'(IMG_H - 1);
        xm    = mode[MIRROR_BIT] ? (ow_m1 - x_q) : x_q;
        sx    = '0;
        sy    = '0;
        case (mode[1:0])
            ROT_0: begin
                sx = XW'(xm);
                sy = YW'(y_q);
            end
            ROT_90: begin
                sx = XW'(y_q);
                sy = YW'(CW'(IMG_H - 1) - xm);
            end
            ROT_180: begin
                sx = XW'(CW'(IMG_W - 1) - xm);
                sy = YW'(CW'(IMG_H - 1) - y_q);
            end
            ROT_270: begin
                sx = XW'(CW'(IMG_W - 1) - y_q);
                sy = YW'(xm);
            end
        endcase
        src_addr  = {sy, sx};
        a         = x_q;
        b         = y_q;
        line_flag = (x_q == ow_m1);
        last      = (x_q == ow_m1) && (y_q == oh_m1);
    end

    // Output raster counters, wrapping exactly at the output dimensions
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (adv) begin
            if (x_q == ow_m1) begin
                x_q <= '0;
                y_q <= (y_q == oh_m1) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/img_rotate_stream.sv
// Buffers one raster-order RGB frame, then streams it out rotated 0/90/180/270 with optional mirror.
// Latency: first output 2 cycles after the last input handshake (3 when ROT_GREY_EN is defined).
// Backpressure: input ready only in IDLE/LOAD; an output stall freezes the read address and pipe.
// Build option ROT_GREY_EN: output replicated luminance instead of the RGB pixel.
module img_rotate_stream #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 24,
    localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H)
) (
    input  logic             axi_clk,
    input  logic             reset,
    input  logic             i_rgb_data_valid,
    input  logic [PIX_W-1:0] i_rgb_data,
    output logic             i_rgb_data_ready,
    input  logic [2:0]       aci,
    output logic             o_rgb_data_valid,
    output logic [PIX_W-1:0] o_rgb_data,
    input  logic             i_rgb_data_ready_out,
    output logic             line_flag,
    output logic [CW-1:0]    a,
    output logic [CW-1:0]    b,
    output logic             frame_done
);
    import img_pkg::*;

    localparam int DEPTH = IMG_W * IMG_H;
    localparam int AW    = $clog2(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];

    state_t        state_q;
    state_t        state_d;
    logic [2:0]    mode_q;
    logic [AW-1:0] wr_addr;
    logic          in_acc;
    logic          wr_last;

    logic [AW-1:0] src_addr;
    logic [CW-1:0] g_a;
    logic [CW-1:0] g_b;
    logic          g_lf;
    logic          g_last;
    logic          iss_done;
    logic          issue;
    logic          en;
    logic          out_hs;
    logic          out_last;

    logic [PIX_W-1:0] rd_dat;
    logic             s1_vld;
    logic             s1_lf;
    logic             s1_last;
    logic [CW-1:0]    s1_a;
    logic [CW-1:0]    s1_b;

    assign i_rgb_data_ready = reset && (state_q != ST_DRAIN);
    assign in_acc           = i_rgb_data_valid && i_rgb_data_ready;
    assign wr_last          = &wr_addr;
    assign issue            = (state_q == ST_DRAIN) && !iss_done && en;
    assign out_hs           = o_rgb_data_valid && i_rgb_data_ready_out;

    // Next-state: idle until the first pixel, load the whole frame, drain until the last handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_acc) state_d = ST_LOAD;
            ST_LOAD:  if (in_acc && wr_last) state_d = ST_DRAIN;
            ST_DRAIN: if (out_hs && out_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axi_clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Mode is captured with the first pixel of a frame and frozen until the next frame
    always_ff @(posedge axi_clk) begin
        if (!reset)                           mode_q <= '0;
        else if (state_q == ST_IDLE && in_acc) mode_q <= aci;
    end

    // Raster write address {y,x}; power-of-two dimensions let it wrap naturally to 0
    always_ff @(posedge axi_clk) begin
        if (!reset)      wr_addr <= '0;
        else if (in_acc) wr_addr <= wr_addr + 1'b1;
    end

    // Frame store write port; contents survive reset
    always_ff @(posedge axi_clk) begin
        if (in_acc) mem[wr_addr] <= i_rgb_data;
    end

    img_rot_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_gen (
        .clk       (axi_clk),
        .reset     (reset),
        .clear     (state_q != ST_DRAIN),
        .adv       (issue),
        .mode      (mode_q),
        .src_addr  (src_addr),
        .a         (g_a),
        .b         (g_b),
        .line_flag (g_lf),
        .last      (g_last)
    );

    // Stops issuing once the final output pixel address has gone to the RAM
    always_ff @(posedge axi_clk) begin
        if (!reset || state_q != ST_DRAIN) iss_done <= 1'b0;
        else if (issue && g_last)          iss_done <= 1'b1;
    end

    // RAM read port: a read happens only when the pipe can accept it, so stalls hold the data
    always_ff @(posedge axi_clk) begin
        if (!reset)     rd_dat <= '0;
        else if (issue) rd_dat <= mem[src_addr];
    end

    // Position/flags travelling alongside the RAM read
    always_ff @(posedge axi_clk) begin
        if (!reset) begin
            s1_vld  <= 1'b0;
            s1_lf   <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (en) begin
            s1_vld <= issue;
            if (issue) begin
                s1_lf   <= g_lf;
                s1_last <= g_last;
                s1_a    <= g_a;
                s1_b    <= g_b;
            end
        end
    end

`ifdef ROT_GREY_EN
    localparam int CH = PIX_W / 3;

    logic [CH+8:0]    luma_sum;
    logic [CH-1:0]    luma;
    logic             s2_vld;
    logic             s2_lf;
    logic             s2_last;
    logic [CW-1:0]    s2_a;
    logic [CW-1:0]    s2_b;
    logic [PIX_W-1:0] s2_dat;

    // Weighted channel sum of the read pixel, scaled back to one channel
    always_comb begin
        luma_sum = (CH+9)'(LUMA_R) * (CH+9)'(rd_dat[CH-1:0])
                 + (CH+9)'(LUMA_G) * (CH+9)'(rd_dat[2*CH-1:CH])
                 + (CH+9)'(LUMA_B) * (CH+9)'(rd_dat[3*CH-1:2*CH]);
        luma     = CH'(luma_sum >> 8);
    end

    // Extra output stage holding the grey pixel; the whole pipe advances together
    always_ff @(posedge axi_clk) begin
        if (!reset) begin
            s2_vld  <= 1'b0;
            s2_lf   <= 1'b0;
            s2_last <= 1'b0;
            s2_a    <= '0;
            s2_b    <= '0;
            s2_dat  <= '0;
        end else if (en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_lf   <= s1_lf;
                s2_last <= s1_last;
                s2_a    <= s1_a;
                s2_b    <= s1_b;
                s2_dat  <= PIX_W'({3{luma}});
            end
        end
    end

    assign en               = !s2_vld || i_rgb_data_ready_out;
    assign o_rgb_data_valid = s2_vld;
    assign o_rgb_data       = s2_dat;
    assign line_flag        = s2_lf;
    assign a                = s2_a;
    assign b                = s2_b;
    assign out_last         = s2_last;
`else
    assign en               = !s1_vld || i_rgb_data_ready_out;
    assign o_rgb_data_valid = s1_vld;
    assign o_rgb_data       = rd_dat;
    assign line_flag        = s1_lf;
    assign a                = s1_a;
    assign b                = s1_b;
    assign out_last         = s1_last;
`endif

    // One-cycle pulse once the final output pixel has been taken downstream
    always_ff @(posedge axi_clk) begin
        if (!reset) frame_done <= 1'b0;
        else        frame_done <= out_hs && out_last;
    end

endmodule

// File: tb/tb_img_rotate_stream.sv
// Bench for img_rotate_stream: a 4x4 and an 8x4 instance share stimulus, one selected at a time.
// Expected pixels/positions are queued when a frame is sent and popped on each output handshake.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_img_rotate_stream;

    typedef struct {
        logic [23:0] d;
        logic [2:0]  a;
        logic [2:0]  b;
        logic        lf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [23:0] dat;
    logic [2:0]  aci;
    logic        rdy_out;
    logic        sel;

    logic        rdy0, ov0, lf0, fd0;
    logic [23:0] od0;
    logic [1:0]  a0, b0;
    logic        rdy1, ov1, lf1, fd1;
    logic [23:0] od1;
    logic [2:0]  a1, b1;

    logic        o_rdy, o_vld, o_lf, o_fd;
    logic [23:0] o_dat;
    logic [2:0]  o_a, o_b;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   rot90_seq[16] = '{12, 8, 4, 0, 13, 9, 5, 1, 14, 10, 6, 2, 15, 11, 7, 3};

    always #5 clk = ~clk;

    img_rotate_stream #(.IMG_W(4), .IMG_H(4), .PIX_W(24)) dut_sq (
        .axi_clk              (clk),
        .reset                (rst_n),
        .i_rgb_data_valid     (vld && !sel),
        .i_rgb_data           (dat),
        .i_rgb_data_ready     (rdy0),
        .aci                  (aci),
        .o_rgb_data_valid     (ov0),
        .o_rgb_data           (od0),
        .i_rgb_data_ready_out (rdy_out),
        .line_flag            (lf0),
        .a                    (a0),
        .b                    (b0),
        .frame_done           (fd0)
    );

    img_rotate_stream #(.IMG_W(8), .IMG_H(4), .PIX_W(24)) dut_wide (
        .axi_clk              (clk),
        .reset                (rst_n),
        .i_rgb_data_valid     (vld && sel),
        .i_rgb_data           (dat),
        .i_rgb_data_ready     (rdy1),
        .aci                  (aci),
        .o_rgb_data_valid     (ov1),
        .o_rgb_data           (od1),
        .i_rgb_data_ready_out (rdy_out),
        .line_flag            (lf1),
        .a                    (a1),
        .b                    (b1),
        .frame_done           (fd1)
    );

    always_comb begin
        if (sel) begin
            o_rdy = rdy1; o_vld = ov1; o_lf = lf1; o_fd = fd1;
            o_dat = od1;  o_a = a1;    o_b = b1;
        end else begin
            o_rdy = rdy0; o_vld = ov0; o_lf = lf0; o_fd = fd0;
            o_dat = od0;  o_a = {1'b0, a0}; o_b = {1'b0, b0};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference mapping: output (x,y) in raster order -> source raster index
    task automatic push_model(input int w, input int h, input logic [2:0] m);
        int ow, oh, xm, sx, sy;
        exp_t e;
        ow = m[0] ? h : w;
        oh = m[0] ? w : h;
        for (int y = 0; y < oh; y++) begin
            for (int x = 0; x < ow; x++) begin
                xm = m[2] ? (ow - 1 - x) : x;
                case (m[1:0])
                    2'd0:    begin sx = xm;        sy = y;          end
                    2'd1:    begin sx = y;         sy = h - 1 - xm; end
                    2'd2:    begin sx = w - 1 - xm; sy = h - 1 - y; end
                    default: begin sx = w - 1 - y; sy = xm;         end
                endcase
                e.d  = 24'(sy * w + sx);
                e.a  = 3'(x);
                e.b  = 3'(y);
                e.lf = (x == ow - 1);
                q.push_back(e);
            end
        end
    endtask

    // Called just after a falling edge; returns just after the edge following the last accept
    task automatic send_frame(input int n);
        int guard;
        for (int i = 0; i < n; i++) begin
            vld = 1'b1;
            dat = 24'(i);
            guard = 0;
            while (!o_rdy && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) check("in_ready_timeout", 32'(o_rdy), 32'd1);
            @(negedge clk);
        end
        vld = 1'b0;
    endtask

    task automatic collect(input int n, input bit rand_rdy);
        int          got = 0;
        int          cyc = 0;
        bit          stall = 1'b0;
        logic [23:0] pd = '0;
        logic [2:0]  pa = '0, pb = '0;
        logic        plf = 1'b0;
        exp_t        e;
        while (got < n && cyc < 2000) begin
            if (stall) begin
                check("hold_vld", 32'(o_vld), 32'd1);
                check("hold_dat", 32'(o_dat), 32'(pd));
                check("hold_a",   32'(o_a),   32'(pa));
                check("hold_b",   32'(o_b),   32'(pb));
                check("hold_lf",  32'(o_lf),  32'(plf));
            end
            rdy_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            check("in_rdy_drain", 32'(o_rdy), 32'd0);
            check("fd_early", 32'(o_fd), 32'd0);
            if (o_vld && rdy_out) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(o_vld), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pix", 32'(o_dat), 32'(e.d));
                    check("col", 32'(o_a),   32'(e.a));
                    check("row", 32'(o_b),   32'(e.b));
                    check("lf",  32'(o_lf),  32'(e.lf));
                end
                got++;
            end
            stall = o_vld && !rdy_out;
            pd = o_dat; pa = o_a; pb = o_b; plf = o_lf;
            @(negedge clk);
            cyc++;
        end
        check("out_count", 32'(got), 32'(n));
    endtask

    task automatic run_frame(input int n, input logic [2:0] m, input bit rand_rdy);
        aci = m;
        send_frame(n);
        aci = ~m;
        rdy_out = 1'b1;
        check("lat_cycle1", 32'(o_vld), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(o_vld), 32'd1);
        collect(n, rand_rdy);
        check("frame_done", 32'(o_fd), 32'd1);
        check("idle_ready", 32'(o_rdy), 32'd1);
        check("idle_vld",   32'(o_vld), 32'd0);
        check("q_drained",  32'(q.size()), 32'd0);
        @(negedge clk);
        check("fd_single", 32'(o_fd), 32'd0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; vld = 1'b0; dat = '0; aci = '0; rdy_out = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(o_rdy), 32'd0);
        check("rst_vld",   32'(o_vld), 32'd0);
        check("rst_dat",   32'(o_dat), 32'd0);
        check("rst_a",     32'(o_a),   32'd0);
        check("rst_b",     32'(o_b),   32'd0);
        check("rst_lf",    32'(o_lf),  32'd0);
        check("rst_fd",    32'(o_fd),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(o_rdy), 32'd1);

        // 4x4 identity
        push_model(4, 4, 3'd0);
        run_frame(16, 3'd0, 1'b0);

        // 4x4 rotate 90, expectations from a literal sequence
        for (int i = 0; i < 16; i++) begin
            e.d  = 24'(rot90_seq[i]);
            e.a  = 3'(i % 4);
            e.b  = 3'(i / 4);
            e.lf = (i % 4 == 3);
            q.push_back(e);
        end
        run_frame(16, 3'd1, 1'b0);

        // 4x4 rotate 180, then mirror without rotation
        push_model(4, 4, 3'd2);
        run_frame(16, 3'd2, 1'b0);
        push_model(4, 4, 3'd4);
        run_frame(16, 3'd4, 1'b0);

        // 8x4 rotate 270: output 4 wide, 8 high
        sel = 1'b1;
        @(negedge clk);
        push_model(8, 4, 3'd3);
        run_frame(32, 3'd3, 1'b0);

        // 4x4 identity with random downstream stalls
        sel = 1'b0;
        @(negedge clk);
        push_model(4, 4, 3'd0);
        run_frame(16, 3'd0, 1'b1);

        // Reset in the middle of the drain, then a fresh full frame
        push_model(4, 4, 3'd0);
        aci = 3'd0;
        send_frame(16);
        rdy_out = 1'b1;
        @(negedge clk);
        collect(5, 1'b0);
        rst_n = 1'b0;
        rdy_out = 1'b0;
        @(negedge clk);
        check("mid_rst_vld",   32'(o_vld), 32'd0);
        check("mid_rst_dat",   32'(o_dat), 32'd0);
        check("mid_rst_a",     32'(o_a),   32'd0);
        check("mid_rst_b",     32'(o_b),   32'd0);
        check("mid_rst_lf",    32'(o_lf),  32'd0);
        check("mid_rst_ready", 32'(o_rdy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle_ready", 32'(o_rdy), 32'd1);
        check("mid_rst_idle_vld",   32'(o_vld), 32'd0);
        q.delete();
        push_model(4, 4, 3'd0);
        run_frame(16, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
